wide_inv_pattern_gen: RTL and testbench
=======================================

# wide_inv_pattern_gen

Upstream stimulus stage for the `wide_inv` datapath. It waits for the consumer's `rdy` and then drives a fixed sequence of 32-bit corner-case words into the consumer's `d_in`, holding each word for a programmable number of cycles. It pauses whenever `rdy` drops and raises a sticky `done` when the sequence is exhausted. It replaces hand-timed stimulus so FPGA and simulation runs use an identical, cycle-exact input stream.

## Interface
- `HOLD_CYCLES`, default 1: cycles each word is held on `data_out`; legal range 1–255.
- `NUM_LFSR`, default 16: count of pseudo-random words appended after the fixed set; legal range 0–200. Used only with the macro.
- `LFSR_SEED`, default 32'h00000001: initial LFSR state; a value of 0 is replaced by 1. Used only with the macro.

- `clock`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rdy`  in  1  consumer ready; sampled on each rising edge.
- `data_out`  out  32  word for the consumer's `d_in`.
- `valid`  out  1  `data_out` carries a sequence word this cycle.
- `pat_idx`  out  8  index of the word currently on `data_out`, starting at 0.
- `done`  out  1  sequence complete; sticky until `rst`.

## Operation
- Fixed set, indices 0–10, in this order: 00000000, ffffffff, ffff0000, 0000ffff, 55555555, aaaaaaaa, 11111111, 22222222, 44444444, 88888888, 00000000.
- The FSM has three states: WAIT_RDY, RUN and DONE.
- WAIT_RDY is entered on reset.
  - Outputs: `data_out`=0, `valid`=0, `pat_idx`=0, `done`=0.
  - Moves to RUN on the first edge where `rdy`=1.
- RUN behaviour:
  - `data_out`=word[`pat_idx`], `valid`=`rdy`.
  - The hold counter counts from 0 to HOLD_CYCLES-1 only on edges where `rdy`=1.
  - When the counter reaches its terminal value with `rdy`=1, `pat_idx` increments and the counter clears.
  - After the last word (index 10, or 10+NUM_LFSR with the macro) completes its hold, the next state is DONE.
- Pause: `rdy`=0 in RUN freezes `pat_idx`, the hold counter and `data_out`, and forces `valid`=0.
  - `rdy` returning to 1 resumes exactly where the sequence stopped. The word is neither skipped nor repeated.
- DONE: `data_out`=0, `valid`=0, `done`=1, and `pat_idx` holds the final index. The state is left only by `rst`; `rdy` is ignored.
- Reset: `rst` asserted in any state returns to WAIT_RDY with reset output values on the next edge. `rst` has priority over `rdy`.
- `pat_idx` is 8 bits and cannot wrap, given the parameter ranges.

## Timing
- All outputs are registered. There is no combinational path from `rdy` to any output.
- Let E0 be the edge at which `rdy`=1 is first sampled in WAIT_RDY.
  - Just after E0: `valid`=1 and `data_out`=word[0].
- With continuous `rdy`=1, word k is valid from E0 + k·HOLD_CYCLES for HOLD_CYCLES cycles.
- `done` rises at E0 + N·HOLD_CYCLES, where N is the total word count: 11, or 11+NUM_LFSR with the macro.
- Each cycle with `rdy`=0 in RUN delays all later transitions by exactly one cycle.
- Reset values: `data_out`=0, `valid`=0, `pat_idx`=0, `done`=0.

## Configuration
- Macro: `WIDE_INV_PATGEN_LFSR_EN`.
- With the macro defined:
  - After index 10, NUM_LFSR words follow at indices 11 to 10+NUM_LFSR.
  - The LFSR is a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1, mask 32'h80200003.
  - The first LFSR word is the seed. The LFSR advances one step each time an LFSR word completes its hold.
  - The LFSR is reloaded from the seed on `rst`.
  - NUM_LFSR=0 behaves identically to the macro being undefined.
- Without the macro: no LFSR logic is present, DONE follows index 10, and NUM_LFSR and LFSR_SEED are ignored.

## Test plan
- Basic sequence: defaults; `rst` high for 2 cycles, `rdy`=1 at edge E0.
  - Expect 00000000, ffffffff, …, 88888888, 00000000 on 11 consecutive cycles with `valid`=1.
  - Expect `done`=1 at E0+11 and `data_out`=0 afterward.
- Hold: HOLD_CYCLES=3.
  - Each word is stable for exactly 3 cycles; for example ffff0000 spans E0+6 to E0+8.
  - `done` rises at E0+33.
- Pause: `rdy` driven to 0 for 4 cycles while 55555555 is on `data_out`.
  - `valid`=0 and `pat_idx`=4 frozen throughout the pause.
  - On resume, 55555555 completes its remaining hold, then aaaaaaaa follows; `done` is delayed by 4 cycles.
- Reset mid-run: `rst` pulsed while `pat_idx`=7.
  - Next cycle: `data_out`=0, `valid`=0, `pat_idx`=0, `done`=0, state WAIT_RDY.
  - The full sequence restarts from word 0 on the next `rdy`.
- LFSR build: macro defined, NUM_LFSR=2, seed 1.
  - Index 11 = 00000001 and index 12 = 80200003.
  - `done` at E0+13.
- Pre-ready: `rdy` held at 0 for 50 cycles after reset.
  - `valid`=0, `data_out`=0 and `done`=0 throughout the 50 cycles.

Source files
------------

// File: rtl/wide_inv_pattern_gen.sv
// Stimulus source for the wide_inv datapath: corner-case words, each held HOLD_CYCLES ready cycles.
// Optional LFSR tail words are enabled with `define WIDE_INV_PATGEN_LFSR_EN.
module wide_inv_pattern_gen #(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter int unsigned NUM_LFSR    = 16,
    parameter logic [31:0] LFSR_SEED   = 32'h0000_0001
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        rdy,
    output logic [31:0] data_out,
    output logic        valid,
    output logic [7:0]  pat_idx,
    output logic        done
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255 || NUM_LFSR > 200) begin : g_param_check
        $error("wide_inv_pattern_gen: parameter out of range");
    end

    typedef enum logic [1:0] {
        WAIT_RDY,
        RUN,
        DONE
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

`ifdef WIDE_INV_PATGEN_LFSR_EN
    localparam logic [7:0]  LAST_IDX  = 8'(10 + NUM_LFSR);
    localparam logic [31:0] SEED      = (LFSR_SEED == 32'h0) ? 32'h0000_0001 : LFSR_SEED;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction
`else
    localparam logic [7:0]  LAST_IDX  = 8'd10;
`endif

    function automatic logic [31:0] fixed_word(input logic [7:0] idx);
        logic [31:0] w;
        case (idx)
            8'd0:    w = 32'h0000_0000;
            8'd1:    w = 32'hffff_ffff;
            8'd2:    w = 32'hffff_0000;
            8'd3:    w = 32'h0000_ffff;
            8'd4:    w = 32'h5555_5555;
            8'd5:    w = 32'haaaa_aaaa;
            8'd6:    w = 32'h1111_1111;
            8'd7:    w = 32'h2222_2222;
            8'd8:    w = 32'h4444_4444;
            8'd9:    w = 32'h8888_8888;
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    state_t      state_q, state_n;
    logic [7:0]  cnt_q, cnt_n;
    logic [7:0]  idx_q, idx_n;
    logic [31:0] data_q, data_n;
    logic        valid_q, valid_n;
    logic        done_q, done_n;
    logic [7:0]  idx_inc;
`ifdef WIDE_INV_PATGEN_LFSR_EN
    logic [31:0] lfsr_q, lfsr_n;
`endif

    assign idx_inc = idx_q + 8'd1;

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        data_n  = data_q;
        valid_n = 1'b0;
        done_n  = done_q;
`ifdef WIDE_INV_PATGEN_LFSR_EN
        lfsr_n  = lfsr_q;
`endif
        case (state_q)
            WAIT_RDY: begin
                cnt_n  = '0;
                idx_n  = '0;
                data_n = '0;
                done_n = 1'b0;
                if (rdy) begin
                    state_n = RUN;
                    data_n  = fixed_word(8'd0);
                    valid_n = 1'b1;
                end
            end
            RUN: begin
                // rdy=0 leaves counter, index and word frozen; only valid drops
                if (rdy) begin
                    valid_n = 1'b1;
                    if (cnt_q == HOLD_LAST) begin
                        cnt_n = '0;
`ifdef WIDE_INV_PATGEN_LFSR_EN
                        if (idx_q > 8'd10) lfsr_n = lfsr_step(lfsr_q);
`endif
                        if (idx_q == LAST_IDX) begin
                            state_n = DONE;
                            data_n  = '0;
                            valid_n = 1'b0;
                            done_n  = 1'b1;
                        end else begin
                            idx_n = idx_inc;
`ifdef WIDE_INV_PATGEN_LFSR_EN
                            // first tail word is the current state (seed), later ones the stepped state
                            if (idx_inc == 8'd11)     data_n = lfsr_q;
                            else if (idx_inc > 8'd11) data_n = lfsr_step(lfsr_q);
                            else                      data_n = fixed_word(idx_inc);
`else
                            data_n = fixed_word(idx_inc);
`endif
                        end
                    end else begin
                        cnt_n = cnt_q + 8'd1;
                    end
                end
            end
            DONE: begin
                data_n = '0;
                done_n = 1'b1;
            end
            default: begin
                state_n = WAIT_RDY;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= WAIT_RDY;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef WIDE_INV_PATGEN_LFSR_EN
            lfsr_q  <= SEED;
`endif
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            done_q  <= done_n;
`ifdef WIDE_INV_PATGEN_LFSR_EN
            lfsr_q  <= lfsr_n;
`endif
        end
    end

    assign data_out = data_q;
    assign valid    = valid_q;
    assign pat_idx  = idx_q;
    assign done     = done_q;

endmodule

// File: tb/tb_wide_inv_pattern_gen.sv
// Scoreboard bench: two generators (hold 1 and hold 3) share rst/rdy; a monitor checks every valid word.
module tb_wide_inv_pattern_gen;

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  i;
    } exp_t;

`ifdef WIDE_INV_PATGEN_LFSR_EN
    localparam int N1 = 13;
`else
    localparam int N1 = 11;
`endif
    localparam int N3       = 11;
    localparam int PAUSE_AT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b0;
    logic [31:0] d1, d3;
    logic        v1, v3, done1, done3;
    logic [7:0]  i1, i3;

    int checks = 0;
    int errors = 0;

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;

    logic [31:0] words [13] = '{
        32'h0000_0000, 32'hffff_ffff, 32'hffff_0000, 32'h0000_ffff,
        32'h5555_5555, 32'haaaa_aaaa, 32'h1111_1111, 32'h2222_2222,
        32'h4444_4444, 32'h8888_8888, 32'h0000_0000,
        32'h0000_0001, 32'h8020_0003
    };

    always #5 clk = ~clk;

    wide_inv_pattern_gen #(
        .HOLD_CYCLES(1),
        .NUM_LFSR(2),
        .LFSR_SEED(32'h0000_0001)
    ) u_h1 (
        .clock(clk), .rst(rst), .rdy(rdy),
        .data_out(d1), .valid(v1), .pat_idx(i1), .done(done1)
    );

    wide_inv_pattern_gen #(
        .HOLD_CYCLES(3),
        .NUM_LFSR(0),
        .LFSR_SEED(32'h0000_0001)
    ) u_h3 (
        .clock(clk), .rst(rst), .rdy(rdy),
        .data_out(d3), .valid(v3), .pat_idx(i3), .done(done3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (v1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL h1_unexpected_valid actual=%h required=no_word", d1);
            end else begin
                e1 = q1.pop_front();
                chk("h1_data", d1, e1.d);
                chk("h1_idx", {24'h0, i1}, {24'h0, e1.i});
            end
        end
        if (v3 === 1'b1) begin
            if (q3.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL h3_unexpected_valid actual=%h required=no_word", d3);
            end else begin
                e3 = q3.pop_front();
                chk("h3_data", d3, e3.d);
                chk("h3_idx", {24'h0, i3}, {24'h0, e3.i});
            end
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_h1_data"},  d1, 32'h0);
        chk({tag, "_h1_valid"}, {31'h0, v1}, 32'h0);
        chk({tag, "_h1_idx"},   {24'h0, i1}, 32'h0);
        chk({tag, "_h1_done"},  {31'h0, done1}, 32'h0);
        chk({tag, "_h3_data"},  d3, 32'h0);
        chk({tag, "_h3_valid"}, {31'h0, v3}, 32'h0);
        chk({tag, "_h3_idx"},   {24'h0, i3}, 32'h0);
        chk({tag, "_h3_done"},  {31'h0, done3}, 32'h0);
    endtask

    task automatic push_all();
        for (int k = 0; k < N1; k++) q1.push_back('{d: words[k], i: 8'(k)});
        for (int k = 0; k < N3; k++)
            for (int r = 0; r < 3; r++) q3.push_back('{d: words[k], i: 8'(k)});
    endtask

    task automatic run_seq(input int pause_len, input bit mid_reset);
        int t, dt1, dt3;
        logic [7:0] frz3;
        rst = 1'b1;
        rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_idle("reset");
        push_all();
        rdy = 1'b1;
        @(negedge clk);
        t = 0;
        dt1 = -1;
        dt3 = -1;
        frz3 = '0;
        while ((dt1 < 0 || dt3 < 0) && t < 3 * N3 + pause_len + 20) begin
            if (done1 && dt1 < 0) dt1 = t;
            if (done3 && dt3 < 0) dt3 = t;
            if (pause_len > 0 && t == PAUSE_AT) frz3 = i3;
            if (pause_len > 0 && t > PAUSE_AT && t <= PAUSE_AT + pause_len) begin
                chk("pause_h1_valid", {31'h0, v1}, 32'h0);
                chk("pause_h1_idx",   {24'h0, i1}, 32'd4);
                chk("pause_h3_valid", {31'h0, v3}, 32'h0);
                chk("pause_h3_idx",   {24'h0, i3}, {24'h0, frz3});
            end
            if (pause_len == 0 && !mid_reset && t >= 6 && t <= 8)
                chk("h3_ffff0000_span", d3, 32'hffff_0000);
            if (pause_len == 0 && !mid_reset && t == 9)
                chk("h3_after_span", d3, 32'h0000_ffff);
            if (mid_reset && t == 7) begin
                chk("midrst_h1_idx_before", {24'h0, i1}, 32'd7);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                rdy = 1'b0;
                check_idle("midrst");
                q1.delete();
                q3.delete();
                return;
            end
            rdy = (pause_len == 0) || !((t + 1) > PAUSE_AT && (t + 1) <= PAUSE_AT + pause_len);
            @(negedge clk);
            t++;
        end
        chk("h1_done_cycle", dt1, N1 + pause_len);
        chk("h3_done_cycle", dt3, 3 * N3 + pause_len);
        chk("h1_final_idx",  {24'h0, i1}, N1 - 1);
        chk("h3_final_idx",  {24'h0, i3}, N3 - 1);
        chk("h1_done_data",  d1, 32'h0);
        chk("h3_done_data",  d3, 32'h0);
        rdy = 1'b0;
        repeat (2) @(negedge clk);
        rdy = 1'b1;
        repeat (2) @(negedge clk);
        chk("h1_done_sticky",  {31'h0, done1}, 32'h1);
        chk("h3_done_sticky",  {31'h0, done3}, 32'h1);
        chk("h1_done_valid",   {31'h0, v1}, 32'h0);
        chk("h1_done_idxhold", {24'h0, i1}, N1 - 1);
        chk("h1_queue_drained", q1.size(), 32'h0);
        chk("h3_queue_drained", q3.size(), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_idle("por");
        for (int c = 0; c < 50; c++) begin
            chk("preready_h1_valid", {31'h0, v1}, 32'h0);
            chk("preready_h1_data",  d1, 32'h0);
            chk("preready_h1_done",  {31'h0, done1}, 32'h0);
            chk("preready_h3_valid", {31'h0, v3}, 32'h0);
            @(negedge clk);
        end
        run_seq(0, 1'b0);
        run_seq(4, 1'b0);
        run_seq(0, 1'b1);
        run_seq(0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
